// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file dump engine: address width,
// register count and the dump FSM state encoding.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dump_state_t;

endpackage

// File: rtl/dump_fifo2.sv
// Two-entry FIFO of {index, data, last} words feeding the dump output stream.
// clear_n empties the FIFO and zeroes both entries so the head fields read 0.
module dump_fifo2
    import regfile_pkg::*;
#(
    parameter int DATAWIDTH = 32
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [REG_ADDR_W-1:0] push_index,
    input  logic [DATAWIDTH-1:0]  push_data,
    input  logic                  push_last,
    output logic                  full,
    output logic                  empty,
    output logic [1:0]            count,
    output logic [REG_ADDR_W-1:0] head_index,
    output logic [DATAWIDTH-1:0]  head_data,
    output logic                  head_last
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       do_push;
    logic       do_pop;

    assign full    = (count_reg == 2'd2);
    assign empty   = (count_reg == 2'd0);
    assign count   = count_reg;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            logic [REG_ADDR_W-1:0] index_reg;
            logic [DATAWIDTH-1:0]  data_reg;
            logic                  last_reg;

            always_ff @(posedge clk) begin
                if (!clear_n) begin
                    index_reg <= '0;
                    data_reg  <= '0;
                    last_reg  <= 1'b0;
                end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
                    index_reg <= push_index;
                    data_reg  <= push_data;
                    last_reg  <= push_last;
                end
            end
        end
    endgenerate

    assign head_index = rd_ptr_reg ? g_entry[1].index_reg : g_entry[0].index_reg;
    assign head_data  = rd_ptr_reg ? g_entry[1].data_reg  : g_entry[0].data_reg;
    assign head_last  = rd_ptr_reg ? g_entry[1].last_reg  : g_entry[0].last_reg;

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
            if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
            count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/regfile_dump.sv
// Debug read-out engine: walks the register file read port 0..NREGS-1 and
// streams each value, tagged with its index, over a valid/ready interface.
module regfile_dump
    import regfile_pkg::*;
#(
    parameter int DATAWIDTH = 32,
    parameter int NREGS     = NUM_REGS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [REG_ADDR_W-1:0] readReg,
    input  logic [DATAWIDTH-1:0]  readData,
    output logic                  outValid,
    input  logic                  outReady,
    output logic [DATAWIDTH-1:0]  outData,
    output logic [REG_ADDR_W-1:0] outIndex,
    output logic                  outLast
);

    localparam int PTR_W = REG_ADDR_W + 1;

    dump_state_t           state_reg, state_next;
    logic [PTR_W-1:0]      issue_ptr_reg;
    logic [REG_ADDR_W-1:0] ret_ptr_reg;
    logic [REG_ADDR_W-1:0] read_addr_reg;
    logic                  issued_reg;
    logic                  inflight_reg;

    logic                  start_accept;
    logic                  issue_en;
    logic                  push_en;
    logic                  pop_en;
    logic                  push_last;
    logic                  credit_ok;
    logic                  fifo_clear_n;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [1:0]            fifo_count;
    logic [2:0]            pending;

    assign busy     = (state_reg == ST_RUN);
    assign done     = (state_reg == ST_DONE);
    assign readReg  = read_addr_reg;
    assign outValid = ~fifo_empty;

    // A read is pending from the cycle its address is issued (issued_reg)
    // until readData is captured (inflight_reg). While the FIFO is full the
    // capture is held: readReg does not move, so readData stays valid.
    always_comb begin
        state_next   = state_reg;
        pop_en       = outValid & outReady;
        start_accept = (state_reg == ST_IDLE) & start;
        pending      = 3'(fifo_count) + 3'(issued_reg) + 3'(inflight_reg);
        credit_ok    = (pending <= (3'd2 + 3'(pop_en)));
        issue_en     = (state_reg == ST_RUN) && (issue_ptr_reg < PTR_W'(NREGS)) && credit_ok;
        push_en      = inflight_reg & (~fifo_full | pop_en);
        push_last    = (ret_ptr_reg == REG_ADDR_W'(NREGS - 1));
        fifo_clear_n = rst_n & ~start_accept;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (pop_en && outLast) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            issue_ptr_reg <= '0;
            ret_ptr_reg   <= '0;
            read_addr_reg <= '0;
            issued_reg    <= 1'b0;
            inflight_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_accept) begin
                // index 0 goes out on the accepting edge
                issue_ptr_reg <= PTR_W'(1);
                ret_ptr_reg   <= '0;
                read_addr_reg <= '0;
                issued_reg    <= 1'b1;
                inflight_reg  <= 1'b0;
            end else begin
                issued_reg   <= issue_en;
                inflight_reg <= issued_reg | (inflight_reg & ~push_en);
                if (issue_en) begin
                    read_addr_reg <= issue_ptr_reg[REG_ADDR_W-1:0];
                    issue_ptr_reg <= issue_ptr_reg + 1'b1;
                end
                if (push_en) ret_ptr_reg <= ret_ptr_reg + 1'b1;
            end
        end
    end

    dump_fifo2 #(.DATAWIDTH(DATAWIDTH)) u_fifo (
        .clk        (clk),
        .clear_n    (fifo_clear_n),
        .push       (push_en),
        .pop        (pop_en),
        .push_index (ret_ptr_reg),
        .push_data  (readData),
        .push_last  (push_last),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .head_index (outIndex),
        .head_data  (outData),
        .head_last  (outLast)
    );

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: a 32-register and a 4-register instance
// driven with fixed and $urandom stimulus, checked against an expected word queue.
module tb_regfile_dump;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_drv;
    logic        ready;
    logic        sel4;

    logic        start32, busy32, done32, ov32, ol32;
    logic [4:0]  rr32, oi32;
    logic [31:0] rd32, od32;
    logic        start4, busy4, done4, ov4, ol4;
    logic [4:0]  rr4, oi4;
    logic [31:0] rd4, od4;

    logic [31:0] rf32 [32];
    logic [31:0] rf4  [32];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // registered read port model: data follows the address by one cycle
    always_ff @(posedge clk) begin
        rd32 <= rf32[rr32];
        rd4  <= rf4[rr4];
    end

    assign start32 = start_drv & ~sel4;
    assign start4  = start_drv & sel4;

    regfile_dump #(.DATAWIDTH(32), .NREGS(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .busy(busy32), .done(done32),
        .readReg(rr32), .readData(rd32), .outValid(ov32), .outReady(ready),
        .outData(od32), .outIndex(oi32), .outLast(ol32)
    );

    regfile_dump #(.DATAWIDTH(32), .NREGS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
        .readReg(rr4), .readData(rd4), .outValid(ov4), .outReady(ready),
        .outData(od4), .outIndex(oi4), .outLast(ol4)
    );

    logic        m_valid, m_last, m_busy, m_done, m_ovf;
    logic [4:0]  m_index, m_rreg;
    logic [31:0] m_data;
    assign m_valid = sel4 ? ov4   : ov32;
    assign m_last  = sel4 ? ol4   : ol32;
    assign m_busy  = sel4 ? busy4 : busy32;
    assign m_done  = sel4 ? done4 : done32;
    assign m_index = sel4 ? oi4   : oi32;
    assign m_rreg  = sel4 ? rr4   : rr32;
    assign m_data  = sel4 ? od4   : od32;
    assign m_ovf   = sel4 ? (dut4.push_en & dut4.fifo_full & ~dut4.pop_en)
                          : (dut32.push_en & dut32.fifo_full & ~dut32.pop_en);

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  m_busy,  0);
        check({tag, "_done"},  m_done,  0);
        check({tag, "_rreg"},  m_rreg,  0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_data"},  m_data,  0);
        check({tag, "_index"}, m_index, 0);
        check({tag, "_last"},  m_last,  0);
    endtask

    // mode 0: ready=1, 1: 6-cycle stall at index 3, 2: toggling ready plus a
    // second start mid-dump, 3: random ready. rst_after>=0 resets after that index.
    task automatic run_dump(input bit use4, input int mode, input int rst_after);
        int n, cyc, got, dones, stall_left, first_valid, last_cyc, done_cyc;
        bit stalled, hs;
        logic [31:0] exp_q[$];
        logic [31:0] exp_d;
        n = use4 ? 4 : 32;
        got = 0; dones = 0; stall_left = 0; stalled = 0;
        first_valid = -1; last_cyc = -1; done_cyc = -1;
        for (int i = 0; i < n; i++) exp_q.push_back(use4 ? rf4[i] : rf32[i]);
        sel4 = use4;
        ready = 1'b1;
        start_drv = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0;
        cyc = 1;
        check("busy_c1", m_busy, 1);
        check("rreg_c1", m_rreg, 0);
        while (cyc < 400) begin
            if (mode == 1 && !stalled && m_valid && m_index == 5'd3) begin
                stalled = 1;
                stall_left = 6;
            end
            if (stall_left > 0) begin
                ready = 1'b0;
                stall_left--;
                check("stall_data", m_data, rf32[3]);
                check("stall_idx", m_index, 3);
            end else begin
                case (mode)
                    2:       ready = (cyc % 2 == 1);
                    3:       ready = 1'($urandom_range(0, 1));
                    default: ready = 1'b1;
                endcase
            end
            if (mode == 2) start_drv = (cyc == 10);
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid) check("issue_ahead", (m_rreg <= m_index + 2), 1);
            check("fifo_ovf", m_ovf, 0);
            hs = m_valid && ready;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 1, 0);
                end else begin
                    exp_d = exp_q.pop_front();
                    check("out_index", m_index, got);
                    check("out_data", m_data, exp_d);
                    check("out_last", m_last, (got == n - 1));
                end
                if (m_last) last_cyc = cyc;
                got++;
            end
            if (m_done) begin
                dones++;
                done_cyc = cyc;
                check("busy_at_done", m_busy, 0);
            end
            if (hs && rst_after >= 0 && m_index == 5'(rst_after)) begin
                @(posedge clk); #1;
                ready = 1'b0;
                rst_n = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check_zero("mid_rst");
                check("no_done_rst", dones + m_done, 0);
                $display("dump use4=%0d mode=%0d reset after index %0d, words=%0d", use4, mode, rst_after, got);
                return;
            end
            if (dones > 0) break;
            @(posedge clk); #1;
            cyc++;
        end
        start_drv = 1'b0;
        check("done_seen", dones, 1);
        check("word_count", got, n);
        if (mode == 1) check("stall_seen", stalled, 1);
        if (mode == 0) begin
            check("first_valid_cyc", first_valid, 3);
            check("last_cyc", last_cyc, n + 2);
            check("done_cyc", done_cyc, n + 3);
        end
        @(posedge clk); #1;
        check("done_pulse", m_done, 0);
        check("busy_after", m_busy, 0);
        $display("dump use4=%0d mode=%0d words=%0d done_cyc=%0d", use4, mode, got, done_cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, done_n;
        for (int i = 0; i < 32; i++) begin
            rf32[i] = 32'hA000_0000 + i;
            rf4[i]  = (i < 4) ? 32'(i + 1) : 32'h0;
        end
        rst_n = 1'b0; start_drv = 1'b0; ready = 1'b0; sel4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("rst32");
        sel4 = 1'b1;
        check_zero("rst4");
        sel4 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_dump(0, 0, -1);
        run_dump(0, 1, -1);
        run_dump(0, 2, -1);
        run_dump(0, 3, 10);
        run_dump(0, 0, -1);
        run_dump(1, 0, -1);

        // start held high on the 4-register instance: back-to-back dumps
        sel4 = 1'b1; ready = 1'b1; start_drv = 1'b1;
        k = 0; done_n = 0;
        for (int c = 1; c <= 24; c++) begin
            @(posedge clk); #1;
            if (c == 24) start_drv = 1'b0;
            if (m_done) begin
                done_n++;
                check("held_done_cyc", c % 8, 7);
            end
            if (m_valid) begin
                check("held_idx", m_index, k % 4);
                check("held_data", m_data, k % 4 + 1);
                k++;
            end
        end
        check("held_words", k, 12);
        check("held_dones", done_n, 3);
        @(posedge clk); #1;
        check("held_idle", m_busy, 0);
        $display("held start: words=%0d dones=%0d", k, done_n);

        for (int i = 0; i < 32; i++) rf32[i] = $urandom;
        run_dump(0, 3, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
